// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard field packer: key codes, field-select
// encodings and the controller state type.
package kbd_pkg;

    localparam logic [7:0] NUL    = 8'h00;
    localparam logic [7:0] BKSP   = 8'h08;
    localparam logic [7:0] ENTER  = 8'h13;
    localparam logic [7:0] DIGIT0 = 8'h30;
    localparam logic [7:0] DIGIT9 = 8'h39;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_CMD  = 2'b01;
    localparam logic [1:0] SEL_NUM  = 2'b10;
    localparam logic [1:0] SEL_NEX  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        ACCEPT = 3'd2,
        CONV   = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [7:0] code);
        return (code >= DIGIT0) && (code <= DIGIT9);
    endfunction

endpackage

// File: rtl/kbd_field_packer_dec_acc.sv
// Digit-serial decimal accumulator: acc <= acc*10 + digit on each step,
// cleared by start.
module dec_acc #(
    parameter int ACC_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (start) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc * ACC_W'(10) + ACC_W'(digit);
        end
    end

endmodule

// File: rtl/kbd_field_packer.sv
// Packs debounced PS/2 key codes into a command byte, a next-command byte or a
// right-aligned decimal field that is converted to binary on Enter.
module kbd_field_packer
    import kbd_pkg::*;
#(
    parameter int NDIG    = 3,
    parameter int VAL_W   = 9,
    parameter int MAX_VAL = 359,
    parameter int HOLDOFF = 10000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          sel,
    input  logic                key_valid,
    input  logic [7:0]          key_code,
    output logic [7:0]          cmd_out,
    output logic [7:0]          nex_out,
    output logic [VAL_W-1:0]    val_out,
    output logic [8*NDIG-1:0]   disp_out,
    output logic                enter_pulse,
    output logic                val_valid,
    output logic                range_err,
    output logic                busy,
    output state_t              dbg_state
);

    localparam int ACC_W  = VAL_W + 4;
    localparam int CNT_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int FILL_W = $clog2(NDIG + 1);
    localparam logic [8*NDIG-1:0] BLANK = {NDIG{DIGIT0}};

    // key_valid is a one-cycle strobe with no back-pressure: a key is taken
    // only in IDLE, any strobe seen in another state is lost.
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt;
    logic [FILL_W-1:0]   conv_idx;
    logic [FILL_W-1:0]   fill_q;
    logic [7:0]          code_q;
    logic [7:0]          pend_q;
    logic [1:0]          sel_q;
    logic [8*NDIG-1:0]   buf_q;
    logic [8*NDIG-1:0]   buf_push;
    logic [8*NDIG-1:0]   buf_pop;
    logic [3:0]          digit;
    logic [ACC_W-1:0]    acc;
    logic                acc_start;
    logic                acc_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_valid) state_d = HOLD;
            HOLD:    if (hold_cnt == CNT_W'(HOLDOFF - 1)) state_d = ACCEPT;
            ACCEPT:  state_d = (sel == SEL_NUM && code_q == ENTER) ? CONV : IDLE;
            CONV:    if (conv_idx == FILL_W'(NDIG - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // New digits enter at the least significant byte; backspace refills the MSD with '0'.
    generate
        if (NDIG > 1) begin : g_multi
            assign buf_push = {buf_q[8*NDIG-9:0], code_q};
            assign buf_pop  = {DIGIT0, buf_q[8*NDIG-1:8]};
        end else begin : g_single
            assign buf_push = code_q;
            assign buf_pop  = DIGIT0;
        end
    endgenerate

    always_comb begin
        digit = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (conv_idx == FILL_W'(i)) digit = buf_q[8*(NDIG-1-i) +: 4];
        end
    end

    assign acc_start = (state_q == ACCEPT);
    assign acc_step  = (state_q == CONV);

    dec_acc #(.ACC_W(ACC_W)) u_dec_acc (
        .clk   (clk),
        .reset (reset),
        .start (acc_start),
        .step  (acc_step),
        .digit (digit),
        .acc   (acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt    <= '0;
            conv_idx    <= '0;
            fill_q      <= '0;
            code_q      <= '0;
            pend_q      <= '0;
            sel_q       <= SEL_NONE;
            buf_q       <= BLANK;
            cmd_out     <= '0;
            nex_out     <= '0;
            val_out     <= '0;
            enter_pulse <= 1'b0;
            val_valid   <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            enter_pulse <= 1'b0;
            val_valid   <= 1'b0;
            range_err   <= 1'b0;
            sel_q       <= sel;
            case (state_q)
                IDLE: begin
                    hold_cnt <= '0;
                    if (sel != sel_q) begin
                        buf_q  <= BLANK;
                        fill_q <= '0;
                        pend_q <= '0;
                    end
                    if (key_valid) code_q <= key_code;
                end
                HOLD: hold_cnt <= hold_cnt + CNT_W'(1);
                ACCEPT: begin
                    conv_idx <= '0;
                    if (code_q != NUL) begin
                        case (sel)
                            SEL_NUM: begin
                                if (code_q == ENTER) begin
                                    enter_pulse <= 1'b1;
                                end else if (code_q == BKSP) begin
                                    buf_q <= buf_pop;
                                    if (fill_q != '0) fill_q <= fill_q - FILL_W'(1);
                                end else if (is_digit(code_q) && fill_q < FILL_W'(NDIG)) begin
                                    buf_q  <= buf_push;
                                    fill_q <= fill_q + FILL_W'(1);
                                end
                            end
                            SEL_CMD, SEL_NEX: begin
                                if (code_q == ENTER) begin
                                    enter_pulse <= 1'b1;
                                    if (sel == SEL_CMD) cmd_out <= pend_q;
                                    else                nex_out <= pend_q;
                                end else begin
                                    pend_q <= code_q;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CONV: conv_idx <= conv_idx + FILL_W'(1);
                DONE: begin
                    if (acc > ACC_W'(MAX_VAL)) begin
                        range_err <= 1'b1;
                    end else begin
                        val_out   <= acc[VAL_W-1:0];
                        val_valid <= 1'b1;
                    end
                    buf_q  <= BLANK;
                    fill_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign disp_out  = buf_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_kbd_field_packer.sv
// Bench for kbd_field_packer: directed key table, multi-cycle corner cases
// and random keys checked against a digit-queue reference model.
module tb_kbd_field_packer;
  import kbd_pkg::*;

  localparam int NDIG    = 3;
  localparam int VAL_W   = 9;
  localparam int MAX_VAL = 359;
  localparam int HOLDOFF = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         sel;
  logic               key_valid;
  logic [7:0]         key_code;
  logic [7:0]         cmd_out;
  logic [7:0]         nex_out;
  logic [VAL_W-1:0]   val_out;
  logic [8*NDIG-1:0]  disp_out;
  logic               enter_pulse;
  logic               val_valid;
  logic               range_err;
  logic               busy;
  state_t             dbg_state;

  kbd_field_packer #(
    .NDIG(NDIG), .VAL_W(VAL_W), .MAX_VAL(MAX_VAL), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .key_valid(key_valid), .key_code(key_code),
    .cmd_out(cmd_out), .nex_out(nex_out), .val_out(val_out), .disp_out(disp_out),
    .enter_pulse(enter_pulse), .val_valid(val_valid), .range_err(range_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor
  int n_ent = 0, n_vv = 0, n_re = 0;
  int ent_cyc = 0, vv_cyc = 0;
  always @(negedge clk) begin
    if (enter_pulse) begin n_ent++; ent_cyc = cyc; end
    if (val_valid)   begin n_vv++;  vv_cyc = cyc;  end
    if (range_err)   n_re++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic press(input logic [7:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    wait_idle();
    @(negedge clk);
  endtask

  task automatic set_sel(input logic [1:0] s);
    @(negedge clk);
    sel = s;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // reference model: the numeric field is a queue of decimal digits
  int         mq[$];
  logic [7:0] m_pend, m_cmd, m_nex;
  int         m_val;
  int         e_ent, e_vv, e_re;
  logic [1:0] m_sel;

  function automatic logic [23:0] model_disp();
    logic [23:0] d = '0;
    for (int i = 0; i < NDIG; i++) begin
      int pos = i - (NDIG - mq.size());
      logic [7:0] b = (pos < 0) ? 8'h30 : 8'(8'h30 + mq[pos]);
      d = (d << 8) | 24'(b);
    end
    return d;
  endfunction

  task automatic model_key(input logic [7:0] c);
    if (c == 8'h00) return;
    if (m_sel == 2'b10) begin
      if (c >= 8'h30 && c <= 8'h39) begin
        if (mq.size() < NDIG) mq.push_back(int'(c) - 48);
      end else if (c == 8'h08) begin
        if (mq.size() > 0) void'(mq.pop_back());
      end else if (c == 8'h13) begin
        int v = 0;
        foreach (mq[i]) v = v * 10 + mq[i];
        e_ent++;
        if (v <= MAX_VAL) begin m_val = v; e_vv++; end
        else e_re++;
        mq.delete();
      end
    end else if (m_sel != 2'b00) begin
      if (c == 8'h13) begin
        e_ent++;
        if (m_sel == 2'b01) m_cmd = m_pend;
        else                m_nex = m_pend;
      end else begin
        m_pend = c;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  code;
    logic [23:0] disp;
    logic [8:0]  val;
    logic [7:0]  cmd;
    logic [7:0]  nex;
    int          ent;
    int          vv;
    int          re;
  } vec_t;

  vec_t vecs[30];
  logic [1:0] cur_sel;
  int b_ent, b_vv, b_re, t_edge;

  initial begin
    reset = 1'b1; sel = 2'b00; key_valid = 1'b0; key_code = 8'h00;
    cur_sel = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset values
    check("rst_disp",  32'(disp_out), 32'h303030);
    check("rst_val",   32'(val_out), 32'd0);
    check("rst_cmd",   32'(cmd_out), 32'd0);
    check("rst_nex",   32'(nex_out), 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_pulses", 32'(n_ent + n_vv + n_re), 32'd0);

    //            sel    code   disp        val    cmd    nex   ent vv re
    vecs[0]  = '{2'd2, 8'h31, 24'h303031, 9'h000, 8'h00, 8'h00, 0, 0, 0};
    vecs[1]  = '{2'd2, 8'h32, 24'h303132, 9'h000, 8'h00, 8'h00, 0, 0, 0};
    vecs[2]  = '{2'd2, 8'h33, 24'h313233, 9'h000, 8'h00, 8'h00, 0, 0, 0};
    vecs[3]  = '{2'd2, 8'h13, 24'h303030, 9'h07B, 8'h00, 8'h00, 1, 1, 0};
    vecs[4]  = '{2'd2, 8'h33, 24'h303033, 9'h07B, 8'h00, 8'h00, 0, 0, 0};
    vecs[5]  = '{2'd2, 8'h36, 24'h303336, 9'h07B, 8'h00, 8'h00, 0, 0, 0};
    vecs[6]  = '{2'd2, 8'h30, 24'h333630, 9'h07B, 8'h00, 8'h00, 0, 0, 0};
    vecs[7]  = '{2'd2, 8'h13, 24'h303030, 9'h07B, 8'h00, 8'h00, 1, 0, 1};
    vecs[8]  = '{2'd2, 8'h34, 24'h303034, 9'h07B, 8'h00, 8'h00, 0, 0, 0};
    vecs[9]  = '{2'd2, 8'h35, 24'h303435, 9'h07B, 8'h00, 8'h00, 0, 0, 0};
    vecs[10] = '{2'd2, 8'h08, 24'h303034, 9'h07B, 8'h00, 8'h00, 0, 0, 0};
    vecs[11] = '{2'd2, 8'h37, 24'h303437, 9'h07B, 8'h00, 8'h00, 0, 0, 0};
    vecs[12] = '{2'd2, 8'h13, 24'h303030, 9'h02F, 8'h00, 8'h00, 1, 1, 0};
    vecs[13] = '{2'd2, 8'h31, 24'h303031, 9'h02F, 8'h00, 8'h00, 0, 0, 0};
    vecs[14] = '{2'd2, 8'h32, 24'h303132, 9'h02F, 8'h00, 8'h00, 0, 0, 0};
    vecs[15] = '{2'd2, 8'h33, 24'h313233, 9'h02F, 8'h00, 8'h00, 0, 0, 0};
    vecs[16] = '{2'd2, 8'h34, 24'h313233, 9'h02F, 8'h00, 8'h00, 0, 0, 0};
    vecs[17] = '{2'd2, 8'h43, 24'h313233, 9'h02F, 8'h00, 8'h00, 0, 0, 0};
    vecs[18] = '{2'd2, 8'h13, 24'h303030, 9'h07B, 8'h00, 8'h00, 1, 1, 0};
    vecs[19] = '{2'd2, 8'h13, 24'h303030, 9'h000, 8'h00, 8'h00, 1, 1, 0};
    vecs[20] = '{2'd2, 8'h00, 24'h303030, 9'h000, 8'h00, 8'h00, 0, 0, 0};
    vecs[21] = '{2'd2, 8'h08, 24'h303030, 9'h000, 8'h00, 8'h00, 0, 0, 0};
    vecs[22] = '{2'd1, 8'h41, 24'h303030, 9'h000, 8'h00, 8'h00, 0, 0, 0};
    vecs[23] = '{2'd1, 8'h13, 24'h303030, 9'h000, 8'h41, 8'h00, 1, 0, 0};
    vecs[24] = '{2'd3, 8'h59, 24'h303030, 9'h000, 8'h41, 8'h00, 0, 0, 0};
    vecs[25] = '{2'd3, 8'h13, 24'h303030, 9'h000, 8'h41, 8'h59, 1, 0, 0};
    vecs[26] = '{2'd0, 8'h13, 24'h303030, 9'h000, 8'h41, 8'h59, 0, 0, 0};
    vecs[27] = '{2'd0, 8'h35, 24'h303030, 9'h000, 8'h41, 8'h59, 0, 0, 0};
    vecs[28] = '{2'd2, 8'h39, 24'h303039, 9'h000, 8'h41, 8'h59, 0, 0, 0};
    vecs[29] = '{2'd1, 8'h13, 24'h303030, 9'h000, 8'h00, 8'h59, 1, 0, 0};

    for (int i = 0; i < 30; i++) begin
      if (vecs[i].sel != cur_sel) begin
        set_sel(vecs[i].sel);
        cur_sel = vecs[i].sel;
      end
      b_ent = n_ent; b_vv = n_vv; b_re = n_re;
      press(vecs[i].code);
      check($sformatf("tbl%0d_disp", i), 32'(disp_out), 32'(vecs[i].disp));
      check($sformatf("tbl%0d_val", i),  32'(val_out),  32'(vecs[i].val));
      check($sformatf("tbl%0d_cmd", i),  32'(cmd_out),  32'(vecs[i].cmd));
      check($sformatf("tbl%0d_nex", i),  32'(nex_out),  32'(vecs[i].nex));
      check($sformatf("tbl%0d_ent", i),  32'(n_ent - b_ent), 32'(vecs[i].ent));
      check($sformatf("tbl%0d_vv", i),   32'(n_vv - b_vv),   32'(vecs[i].vv));
      check($sformatf("tbl%0d_re", i),   32'(n_re - b_re),   32'(vecs[i].re));
    end

    // latency: key edge to ACCEPT, enter_pulse to val_valid
    set_sel(2'b00);
    set_sel(2'b10);
    cur_sel = 2'b10;
    press(8'h31); press(8'h32); press(8'h33);
    @(negedge clk);
    key_valid = 1'b1; key_code = 8'h13;
    t_edge = cyc + 1;
    @(negedge clk);
    key_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("lat_enter", 32'(ent_cyc), 32'(t_edge + HOLDOFF + 1));
    check("lat_valid", 32'(vv_cyc - ent_cyc), 32'(NDIG + 1));
    check("lat_val",   32'(val_out), 32'd123);

    // second strobe while in HOLD is dropped
    set_sel(2'b00);
    set_sel(2'b10);
    @(negedge clk);
    key_valid = 1'b1; key_code = 8'h35;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    check("hold_busy", {31'd0, busy}, 32'd1);
    key_valid = 1'b1; key_code = 8'h37;
    @(negedge clk);
    key_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("hold_drop_disp", 32'(disp_out), 32'h303035);

    // reset in the middle of a conversion
    b_vv = n_vv; b_re = n_re;
    @(negedge clk);
    key_valid = 1'b1; key_code = 8'h13;
    @(negedge clk);
    key_valid = 1'b0;
    for (int n = 0; n < 20 && !enter_pulse; n++) @(negedge clk);
    check("conv_enter_seen", {31'd0, enter_pulse}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("conv_rst_state", 32'(dbg_state), 32'(IDLE));
    check("conv_rst_disp",  32'(disp_out), 32'h303030);
    check("conv_rst_val",   32'(val_out), 32'd0);
    check("conv_rst_cmd",   32'(cmd_out), 32'd0);
    check("conv_rst_nex",   32'(nex_out), 32'd0);
    check("conv_rst_pulse", {29'd0, enter_pulse, val_valid, range_err}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("conv_rst_no_vv", 32'(n_vv - b_vv), 32'd0);
    check("conv_rst_no_re", 32'(n_re - b_re), 32'd0);

    // random keys against the reference model
    do_reset();
    mq.delete();
    m_pend = '0; m_cmd = '0; m_nex = '0; m_val = 0;
    m_sel = cur_sel;
    e_ent = n_ent; e_vv = n_vv; e_re = n_re;
    for (int k = 0; k < 150; k++) begin
      logic [7:0] c;
      int r;
      if ($urandom_range(0, 5) == 0) begin
        logic [1:0] s = 2'($urandom_range(0, 3));
        set_sel(s);
        if (s != m_sel) begin
          mq.delete();
          m_pend = '0;
        end
        m_sel = s;
      end
      r = $urandom_range(0, 11);
      if (r <= 5)       c = 8'(8'h30 + $urandom_range(0, 9));
      else if (r == 6)  c = 8'h13;
      else if (r == 7)  c = 8'h08;
      else if (r == 8)  c = 8'h00;
      else              c = 8'($urandom_range(0, 255));
      press(c);
      model_key(c);
      check($sformatf("rnd%0d_disp", k), 32'(disp_out), 32'(model_disp()));
      check($sformatf("rnd%0d_val", k),  32'(val_out),  32'(m_val));
      check($sformatf("rnd%0d_cmd", k),  32'(cmd_out),  32'(m_cmd));
      check($sformatf("rnd%0d_nex", k),  32'(nex_out),  32'(m_nex));
      check($sformatf("rnd%0d_ent", k),  32'(n_ent), 32'(e_ent));
      check($sformatf("rnd%0d_vv", k),   32'(n_vv),  32'(e_vv));
      check($sformatf("rnd%0d_re", k),   32'(n_re),  32'(e_re));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
